axi4_sort_dma: RTL and testbench
================================

AXI4_SORT_DMA -- requirements
Module: axi4_sort_dma

Interface
REQ-001 SHALL have parameter LOG_INPUT_NUM, default 4, setting the maximum burst length 2**LOG_INPUT_NUM words.
REQ-002 SHALL have parameter DATAWIDTH, default 32, setting the data path width; only 32 is supported.
REQ-003 SHALL use one clock and an asynchronous, active-high reset:
- clk  input  1  rising-edge clock for all logic.
- rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have the command ports:
- start  input  1  one-cycle pulse; launches a job.
- src_addr  input  32  byte address of the first source word.
- dst_addr  input  32  byte address of the first destination word.
- count  input  LOG_INPUT_NUM+1  number of words.
- busy  output  1  high while a job runs.
- done  output  1  one-cycle pulse at job end.
- err  output  1  sticky error flag.
REQ-005 SHALL have the AXI4-lite master ports, all 32-bit unless stated:
- mem_axi_awvalid/awready, mem_axi_awaddr, mem_axi_awprot [2:0].
- mem_axi_wvalid/wready, mem_axi_wdata, mem_axi_wstrb [3:0].
- mem_axi_bvalid/bready.
- mem_axi_arvalid/arready, mem_axi_araddr, mem_axi_arprot [2:0].
- mem_axi_rvalid/rready, mem_axi_rdata.
REQ-006 SHALL have the sorter ports:
- sort_din  output  32  word to sorter.
- sort_push  output  1  one-cycle load strobe.
- sort_y_valid  input  1  sorter finished.
- sort_dout  input  32  current sorted word.
- sort_pop  output  1  one-cycle advance strobe.

Function
REQ-007 SHALL implement the FSM IDLE -> RD_ADDR -> RD_DATA -> PUSH, with PUSH looping back to RD_ADDR until count words are read, then WAIT_SORT -> WR_REQ -> WR_RESP -> POP, with POP looping back to WR_REQ until count words are written, then DONE -> IDLE.
REQ-008 IDLE SHALL latch src_addr, dst_addr and count when start=1 and SHALL move to RD_ADDR on the next edge; start SHALL be ignored when not in IDLE.
REQ-009 A count above 2**LOG_INPUT_NUM SHALL be clamped to 2**LOG_INPUT_NUM; count=0 SHALL go IDLE -> DONE with no AXI or sorter traffic.
REQ-010 RD_ADDR SHALL assert arvalid with araddr = src + 4*i and arprot = 3'b000, held stable until the arready handshake.
REQ-011 RD_DATA SHALL hold rready=1, capture rdata on the rvalid handshake, and then move to PUSH.
REQ-012 PUSH SHALL last exactly one cycle, driving sort_push=1 with sort_din equal to the captured word.
REQ-013 WAIT_SORT SHALL stay until sort_y_valid=1.
REQ-014 WR_REQ SHALL assert awvalid and wvalid in the same cycle:
- awaddr = dst + 4*j, wdata = sort_dout sampled on WR_REQ entry, wstrb = 4'hF, awprot = 3'b000.
- Each valid SHALL drop independently on its own handshake; the FSM leaves WR_REQ only after both handshakes, in either order or simultaneously.
REQ-015 WR_RESP SHALL hold bready=1 until bvalid, and then move to POP.
REQ-016 POP SHALL last exactly one cycle with sort_pop=1.
REQ-017 DONE SHALL last exactly one cycle with done=1; busy SHALL be 1 in every state except IDLE.
REQ-018 All AXI valids SHALL be registered outputs, and no valid SHALL depend combinationally on any ready.
REQ-019 Address arithmetic SHALL be modulo 2**32 (wrap silently).

Reset
REQ-020 Asserting rst SHALL immediately force the state to IDLE and set every valid, ready, strobe, busy, done, err and counter to 0, including mid-job.
REQ-021 Jobs aborted by reset SHALL NOT resume; sorter contents are not cleared by this block.

Configuration
REQ-022 Macro SORT_DMA_ALIGN_CHECK_EN:
- Defined: start with src_addr[1:0] or dst_addr[1:0] nonzero SHALL go IDLE -> DONE with err=1 and no traffic. err SHALL clear only on the next accepted start or on reset.
- Undefined: address bits [1:0] SHALL be forced to 0, and err SHALL be tied to 0.

Verification
REQ-023 Stimulus: count=4, src=0x100 holding {9,3,7,1}, slave responds with zero wait states. Required: ARADDR sequence 0x100/104/108/10C, then four sort_push pulses with 9,3,7,1.
REQ-024 Stimulus: sort_y_valid rises, sort_dout steps 1,3,7,9 per pop, dst=0x200. Required: writes 0x200=1, 0x204=3, 0x208=7, 0x20C=9, then one done pulse.
REQ-025 Stimulus: awready returns 3 cycles after wready. Required: wvalid drops after its handshake, awvalid stays high until its own, and exactly one write is issued.
REQ-026 Stimulus: rst asserted during RD_DATA of word 2. Required: all outputs 0 in the same cycle, and a new start with count=2 completes normally.
REQ-027 Stimulus: with SORT_DMA_ALIGN_CHECK_EN defined, start with src=0x102. Required: done and err set within 2 cycles and no arvalid. Without the macro, the same start reads from 0x100.
REQ-028 Stimulus: count=0. Required: done 2 cycles after start, and no AXI transaction.

Source files
------------

// File: rtl/axi4_sort_dma.sv
// axi4_sort_dma: reads a block of words over AXI4-lite and feeds them to an
// external sorter. Once the sorter reports completion, it drains the sorted
// words and writes them back over AXI4-lite.
//
// Optional build macro SORT_DMA_ALIGN_CHECK_EN:
//   - Defined: a start with misaligned src/dst addresses finishes at once
//     with err set, and issues no bus or sorter traffic.
//   - Undefined: address bits [1:0] are dropped and err is always 0.
//
// Handshake rule on every AXI channel: a transfer happens on the rising edge
// where valid and ready are both 1. Once raised, a valid holds its payload
// until that edge. Every valid is a register, so none of them depends on a
// ready within the same cycle.
module axi4_sort_dma #(
  parameter int LOG_INPUT_NUM = 4,
  parameter int DATAWIDTH     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  // command
  input  logic                     start,
  input  logic [31:0]              src_addr,
  input  logic [31:0]              dst_addr,
  input  logic [LOG_INPUT_NUM:0]   count,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  // AXI4-lite write address
  output logic                     mem_axi_awvalid,
  input  logic                     mem_axi_awready,
  output logic [31:0]              mem_axi_awaddr,
  output logic [2:0]               mem_axi_awprot,
  // AXI4-lite write data
  output logic                     mem_axi_wvalid,
  input  logic                     mem_axi_wready,
  output logic [DATAWIDTH-1:0]     mem_axi_wdata,
  output logic [3:0]               mem_axi_wstrb,
  // AXI4-lite write response
  input  logic                     mem_axi_bvalid,
  output logic                     mem_axi_bready,
  // AXI4-lite read address
  output logic                     mem_axi_arvalid,
  input  logic                     mem_axi_arready,
  output logic [31:0]              mem_axi_araddr,
  output logic [2:0]               mem_axi_arprot,
  // AXI4-lite read data
  input  logic                     mem_axi_rvalid,
  output logic                     mem_axi_rready,
  input  logic [DATAWIDTH-1:0]     mem_axi_rdata,
  // sorter
  output logic [DATAWIDTH-1:0]     sort_din,
  output logic                     sort_push,
  input  logic                     sort_y_valid,
  input  logic [DATAWIDTH-1:0]     sort_dout,
  output logic                     sort_pop,
  // debug: current FSM state encoding
  output logic [3:0]               dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_RD_ADDR   = 4'd1,
    S_RD_DATA   = 4'd2,
    S_PUSH      = 4'd3,
    S_WAIT_SORT = 4'd4,
    S_WR_REQ    = 4'd5,
    S_WR_RESP   = 4'd6,
    S_POP       = 4'd7,
    S_DONE      = 4'd8
  } state_t;

  localparam logic [LOG_INPUT_NUM:0] MAX_CNT = {1'b1, {LOG_INPUT_NUM{1'b0}}};

  state_t                  state, state_nx;
  logic [31:0]             src_q, dst_q;
  logic [LOG_INPUT_NUM:0]  cnt_q, rd_idx, wr_idx;
  logic [LOG_INPUT_NUM:0]  rd_idx_inc, wr_idx_inc, count_clamped;
  logic [DATAWIDTH-1:0]    rd_word, wr_word;
  logic                    arvalid_q, awvalid_q, wvalid_q, err_q;
  logic                    misaligned;

`ifdef SORT_DMA_ALIGN_CHECK_EN
  assign misaligned = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);
  assign err        = err_q;
`else
  assign misaligned = 1'b0;
  assign err        = 1'b0;
`endif

  assign count_clamped = (count > MAX_CNT) ? MAX_CNT : count;
  assign rd_idx_inc    = rd_idx + 1'b1;
  assign wr_idx_inc    = wr_idx + 1'b1;

  // State register; reset abandons any job in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:      if (start) state_nx = (count == '0 || misaligned) ? S_DONE : S_RD_ADDR;
      S_RD_ADDR:   if (arvalid_q && mem_axi_arready) state_nx = S_RD_DATA;
      S_RD_DATA:   if (mem_axi_rvalid) state_nx = S_PUSH;
      S_PUSH:      state_nx = (rd_idx_inc == cnt_q) ? S_WAIT_SORT : S_RD_ADDR;
      S_WAIT_SORT: if (sort_y_valid) state_nx = S_WR_REQ;
      // Both channels may complete in either order; an already-dropped
      // valid means that channel's transfer is finished.
      S_WR_REQ:    if ((!awvalid_q || mem_axi_awready) && (!wvalid_q || mem_axi_wready))
                     state_nx = S_WR_RESP;
      S_WR_RESP:   if (mem_axi_bvalid) state_nx = S_POP;
      S_POP:       state_nx = (wr_idx_inc == cnt_q) ? S_DONE : S_WR_REQ;
      S_DONE:      state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end

  // Job registers, word buffers and registered valids.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q     <= '0;
      dst_q     <= '0;
      cnt_q     <= '0;
      rd_idx    <= '0;
      wr_idx    <= '0;
      rd_word   <= '0;
      wr_word   <= '0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        src_q  <= src_addr & 32'hFFFF_FFFC;
        dst_q  <= dst_addr & 32'hFFFF_FFFC;
        cnt_q  <= count_clamped;
        rd_idx <= '0;
        wr_idx <= '0;
        err_q  <= misaligned;
      end
      if (state == S_RD_DATA && mem_axi_rvalid) rd_word <= mem_axi_rdata;
      if (state == S_PUSH) rd_idx <= rd_idx_inc;
      if (state == S_POP)  wr_idx <= wr_idx_inc;
      // Raised on entry to RD_ADDR; drops on the edge that takes the handshake.
      arvalid_q <= (state_nx == S_RD_ADDR);
      if (state != S_WR_REQ && state_nx == S_WR_REQ) begin
        awvalid_q <= 1'b1;
        wvalid_q  <= 1'b1;
        wr_word   <= sort_dout;
      end else begin
        if (mem_axi_awready) awvalid_q <= 1'b0;
        if (mem_axi_wready)  wvalid_q  <= 1'b0;
      end
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

  assign mem_axi_arvalid = arvalid_q;
  assign mem_axi_araddr  = src_q + (32'(rd_idx) << 2);
  assign mem_axi_arprot  = 3'b000;
  assign mem_axi_rready  = (state == S_RD_DATA);

  assign mem_axi_awvalid = awvalid_q;
  assign mem_axi_awaddr  = dst_q + (32'(wr_idx) << 2);
  assign mem_axi_awprot  = 3'b000;
  assign mem_axi_wvalid  = wvalid_q;
  assign mem_axi_wdata   = wr_word;
  assign mem_axi_wstrb   = 4'hF;
  assign mem_axi_bready  = (state == S_WR_RESP);

  assign sort_din  = rd_word;
  assign sort_push = (state == S_PUSH);
  assign sort_pop  = (state == S_POP);

endmodule

// File: tb/tb_axi4_sort_dma.sv
// Bench for axi4_sort_dma. It models an AXI4-lite memory slave and a sorter.
// Expected read addresses, pushed words and writes go into queues when a job
// is set up, and are popped as the DUT produces them.
module tb_axi4_sort_dma;

  typedef logic [31:0] wq_t[$];

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [4:0]  cnt;
    int          aw_delay;
    bit          fixed;
    bit          spurious;
    int          exp_words;
    logic        exp_err;
  } job_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0, dst_addr = '0;
  logic [4:0]  count = '0;
  logic        busy, done, err;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb, dbg_state;
  logic [31:0] sort_din, sort_dout;
  logic        sort_push, sort_pop, sort_y_valid;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [0:1023];
  logic [31:0]  exp_ar_q[$];
  logic [31:0]  exp_push_q[$];
  logic [63:0]  exp_wr_q[$];

  int aw_delay = 0;
  int job_words = 0;
  int done_cnt = 0;
  int ar_cnt = 0;

  axi4_sort_dma dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .count(count), .busy(busy), .done(done), .err(err),
    .mem_axi_awvalid(awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(awaddr),
    .mem_axi_awprot(awprot), .mem_axi_wvalid(wvalid), .mem_axi_wready(wready),
    .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb), .mem_axi_bvalid(bvalid),
    .mem_axi_bready(bready), .mem_axi_arvalid(arvalid), .mem_axi_arready(arready),
    .mem_axi_araddr(araddr), .mem_axi_arprot(arprot), .mem_axi_rvalid(rvalid),
    .mem_axi_rready(rready), .mem_axi_rdata(rdata), .sort_din(sort_din),
    .sort_push(sort_push), .sort_y_valid(sort_y_valid), .sort_dout(sort_dout),
    .sort_pop(sort_pop), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic wq_t sort_words(input wq_t in);
    wq_t q;
    logic [31:0] t;
    q = in;
    for (int a = 1; a < q.size(); a++)
      for (int b = a; b > 0 && q[b-1] > q[b]; b--) begin
        t = q[b]; q[b] = q[b-1]; q[b-1] = t;
      end
    return q;
  endfunction

  // AXI slave: zero-wait reads, optional delayed awready, and the scoreboard
  // checks on each handshake. Handshake flags describe the coming posedge.
  bit ar_hs, r_hs, aw_hs, w_hs, b_hs, aw_got, w_got;
  int aw_wait;
  logic [31:0] ar_addr_l, aw_addr_l, w_data_l;
  logic [63:0] wr_exp;
  always @(negedge clk) begin
    if (rst) begin
      arready = 0; rvalid = 0; rdata = '0; awready = 0; wready = 0; bvalid = 0;
      ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
      aw_got = 0; w_got = 0; aw_wait = 0;
    end else begin
      if (r_hs) rvalid = 0;
      if (ar_hs) begin rvalid = 1; rdata = mem[ar_addr_l[11:2]]; end
      if (aw_hs) aw_got = 1;
      if (w_hs) w_got = 1;
      if (b_hs) begin bvalid = 0; aw_got = 0; w_got = 0; aw_wait = 0; end
      if (aw_got && w_got && !bvalid) bvalid = 1;
      if (w_got && !aw_got) aw_wait++;

      arready = arvalid && !rvalid;
      wready  = wvalid && !w_got;
      awready = awvalid && !aw_got && (aw_delay == 0 || (w_got && aw_wait >= aw_delay));

      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      b_hs  = bvalid && bready;

      if (ar_hs) begin
        ar_addr_l = araddr;
        ar_cnt++;
        if (exp_ar_q.size() == 0) chk("ar_unexpected", {32'h0, araddr}, 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("araddr", araddr, exp_ar_q.pop_front());
        chk("arprot", arprot, 3'b000);
      end
      if (aw_hs) begin
        aw_addr_l = awaddr;
        chk("aw_attr", {awprot, wstrb}, 7'b000_1111);
        if (aw_delay > 0) chk("wvalid_dropped", wvalid, 1'b0);
      end
      if (w_hs) w_data_l = wdata;
      if (b_hs) begin
        wr_exp = (exp_wr_q.size() == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : exp_wr_q.pop_front();
        chk("write", {aw_addr_l, w_data_l}, wr_exp);
      end
      if (sort_push) begin
        if (exp_push_q.size() == 0) chk("push_unexpected", sort_din, 32'hFFFF_FFFF);
        else chk("sort_din", sort_din, exp_push_q.pop_front());
      end
      if (done) done_cnt++;
    end
  end

  // Sorter model: collects pushes, raises y_valid a few cycles after the
  // last one, then steps through the sorted words on each pop.
  wq_t sbuf, sorted;
  int pop_idx = 0, settle = 0;
  initial begin sort_y_valid = 0; sort_dout = '0; end
  always @(negedge clk) begin
    if (start && !busy) begin
      sbuf.delete(); sorted.delete(); pop_idx = 0; settle = 0;
      sort_y_valid = 0; sort_dout = '0;
    end else begin
      if (sort_push) sbuf.push_back(sort_din);
      if (!sort_y_valid && job_words != 0 && sbuf.size() == job_words) begin
        settle++;
        if (settle == 3) begin
          sorted = sort_words(sbuf);
          sort_y_valid = 1;
          sort_dout = sorted[0];
        end
      end
      if (sort_pop) begin
        pop_idx++;
        if (pop_idx < sorted.size()) sort_dout = sorted[pop_idx];
      end
    end
  end

  // driver: set up expectations, launch the job, wait for done, check end state
  task automatic run_job(input job_t j);
    wq_t data, srt;
    logic [31:0] base, a, v, fixed_data[4];
    int n, lat, d0;
    fixed_data = '{32'd9, 32'd3, 32'd7, 32'd1};
    n = j.exp_words;
    base = j.src & 32'hFFFF_FFFC;
    for (int k = 0; k < n; k++) begin
      v = j.fixed ? fixed_data[k] : $urandom;
      a = base + 32'(k) * 4;
      mem[a[11:2]] = v;
      data.push_back(v);
      exp_ar_q.push_back(a);
      exp_push_q.push_back(v);
    end
    srt = sort_words(data);
    for (int k = 0; k < n; k++) exp_wr_q.push_back({(j.dst & 32'hFFFF_FFFC) + 32'(k) * 4, srt[k]});
    aw_delay = j.aw_delay;
    job_words = n;
    d0 = done_cnt;
    @(posedge clk); #1;
    src_addr = j.src; dst_addr = j.dst; count = j.cnt; start = 1;
    @(posedge clk); #1;
    start = 0;
    lat = 1;
    if (n > 0) chk("busy_running", busy, 1'b1);
    while (!done && lat < 3000) begin
      start = (j.spurious && lat == 8);
      if (start) src_addr = 32'h0;
      @(posedge clk); #1;
      lat++;
    end
    start = 0;
    chk("done_timeout", lat < 3000, 1'b1);
    if (n == 0) chk("done_latency", lat <= 2, 1'b1);
    chk("err", err, j.exp_err);
    repeat (2) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt - d0, 1);
    chk("busy_idle", busy, 1'b0);
    chk("err_sticky", err, j.exp_err);
    chk("ar_left", exp_ar_q.size(), 0);
    chk("push_left", exp_push_q.size(), 0);
    chk("wr_left", exp_wr_q.size(), 0);
    exp_ar_q.delete(); exp_push_q.delete(); exp_wr_q.delete();
  endtask

  job_t jobs[9];
  job_t rj;
  int ar0, cyc;

  initial begin
    //        src            dst            cnt    awd fix spur words err
    jobs[0] = '{32'h100,       32'h200,       5'd4,  0, 1, 0, 4,  1'b0};
    jobs[1] = '{32'h300,       32'h380,       5'd1,  0, 0, 0, 1,  1'b0};
    jobs[2] = '{32'h400,       32'h600,       5'd16, 0, 0, 1, 16, 1'b0};
    jobs[3] = '{32'h800,       32'hA00,       5'd20, 0, 0, 0, 16, 1'b0};
    jobs[4] = '{32'h140,       32'h240,       5'd3,  3, 0, 0, 3,  1'b0};
    jobs[5] = '{32'h180,       32'h280,       5'd0,  0, 0, 0, 0,  1'b0};
`ifdef SORT_DMA_ALIGN_CHECK_EN
    jobs[6] = '{32'h102,       32'h200,       5'd4,  0, 0, 0, 0,  1'b1};
`else
    jobs[6] = '{32'h102,       32'h200,       5'd4,  0, 0, 0, 4,  1'b0};
`endif
    jobs[7] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 5'd4,  0, 0, 0, 4,  1'b0};
    jobs[8] = '{32'h1C0,       32'h2C0,       5'd7,  1, 0, 0, 7,  1'b0};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flags", {busy, done, err}, 3'b000);
    chk("rst_valids", {arvalid, awvalid, wvalid}, 3'b000);
    chk("rst_readys_strobes", {rready, bready, sort_push, sort_pop}, 4'b0000);
    chk("rst_state", dbg_state, 4'd0);
    rst = 0;

    foreach (jobs[i]) run_job(jobs[i]);

    // reset during the read-data phase of the second word
    exp_ar_q.push_back(32'h100); exp_ar_q.push_back(32'h104);
    mem[32'h100 >> 2] = 32'h55; exp_push_q.push_back(32'h55);
    job_words = 4; aw_delay = 0;
    ar0 = ar_cnt;
    @(posedge clk); #1;
    src_addr = 32'h100; dst_addr = 32'h200; count = 5'd4; start = 1;
    @(posedge clk); #1;
    start = 0;
    cyc = 0;
    while (!(dbg_state == 4'd2 && ar_cnt - ar0 == 2) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rd2_reached", cyc < 200, 1'b1);
    chk("pre_rst_rready", rready, 1'b1);
    #1 rst = 1;
    #1;
    chk("abort_outputs", {busy, done, err, arvalid, rready, awvalid, wvalid, bready, sort_push, sort_pop}, 10'b0);
    chk("abort_state", dbg_state, 4'd0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    exp_ar_q.delete(); exp_push_q.delete(); exp_wr_q.delete();
    rj = '{32'h500, 32'h580, 5'd2, 0, 0, 0, 2, 1'b0};
    run_job(rj);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
